lc3_mem_resp: RTL and testbench



---
 rtl/lc3_mem_resp_pkg.sv | 19 +
 rtl/lc3_mem_resp_ram.sv | 58 +++++
 rtl/lc3_mem_resp.sv | 175 +++++++++++++++++
 tb/tb_lc3_mem_resp.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_resp_pkg.sv
// lc3_mem_resp_pkg
// Shared definitions for the LC3 memory responder:
//   state_e         - responder FSM states (IDLE, WAIT, RESP)
//   *_DEF constants - default data width, address width, log2 depth and
//                     wait-count width used as parameter defaults.
package lc3_mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int DATA_W_DEF     = 16;
   localparam int ADDR_W_DEF     = 16;
   localparam int DEPTH_LOG2_DEF = 8;
   localparam int WAIT_W_DEF     = 4;

endpackage

// File: rtl/lc3_mem_resp_ram.sv
// lc3_mem_resp_ram
// Single-port synchronous storage of 2^DEPTH_LOG2 words x DATA_W bits.
// Ports:
//   clock, reset - clock and asynchronous active-high reset (read register only)
//   en           - perform an access this edge
//   we           - 1 = write wdata to addr, 0 = read addr
//   addr, wdata  - access address and write data
//   rdata        - registered read data; a write returns the data written
module lc3_mem_resp_ram
   import lc3_mem_resp_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      rdata_d = rdata_q;
      if (en) begin
         rdata_d = we ? wdata : mem[addr];
      end
   end

   // NOTE: the storage array has no reset; clearing it would turn a RAM into
   // thousands of resettable flops. Only the read register is reset.
   always_ff @(posedge clock) begin
      if (en && we) begin
         mem[addr] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its inputs from before the edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/lc3_mem_resp.sv
// lc3_mem_resp
// Memory responder for one LC3 request stream (imem or dmem). Accepts one
// request at a time over a valid/ready handshake, inserts wait_cycles wait
// states, performs the access on entry to RESP and holds the response until
// the consumer takes it.
// Ports:
//   clock, reset          - clock, asynchronous active-high reset
//   wait_cycles           - wait states for the next accepted request
//   req_valid/req_ready   - request handshake
//   req_we/addr/wdata     - request contents (word address)
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata             - read data, or the written data for writes
//   rsp_err               - out-of-range flag (LC3_MEM_RESP_OOR_EN only)
// Optional feature: define LC3_MEM_RESP_OOR_EN to flag and suppress accesses
// whose address has any bit set at or above DEPTH_LOG2. Without it, addresses
// alias modulo 2^DEPTH_LOG2.
module lc3_mem_resp
   import lc3_mem_resp_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int WAIT_W     = WAIT_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WAIT_W-1:0] wait_cycles,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata
`ifdef LC3_MEM_RESP_OOR_EN
   ,
   output logic              rsp_err
`endif
);

   state_e                state_q, state_d;
   logic [WAIT_W-1:0]     cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [DEPTH_LOG2-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;

   logic                  accept;
   logic                  ram_en;
   logic                  ram_we;
   logic                  acc_we;
   logic                  acc_oor;
   logic [DEPTH_LOG2-1:0] acc_addr;
   logic [DATA_W-1:0]     acc_wdata;
   logic [DATA_W-1:0]     ram_rdata;

   assign req_ready = (state_q == IDLE) && !reset;
   assign rsp_valid = (state_q == RESP);
   assign accept    = req_valid && req_ready;

   // A zero-wait request hits storage on its acceptance edge, before the
   // request has been latched, so the access comes straight from the port.
   assign acc_we    = accept ? req_we                   : we_q;
   assign acc_addr  = accept ? req_addr[DEPTH_LOG2-1:0] : addr_q;
   assign acc_wdata = accept ? req_wdata                : wdata_q;

`ifdef LC3_MEM_RESP_OOR_EN
   logic oor_q, oor_d;
   logic err_q, err_d;

   assign acc_oor   = accept ? ((req_addr >> DEPTH_LOG2) != '0) : oor_q;
   assign rsp_err   = err_q;
   assign rsp_rdata = err_q ? '0 : ram_rdata;

   always_comb begin
      oor_d = oor_q;
      err_d = err_q;
      if (accept) begin
         oor_d = acc_oor;
      end
      if (ram_en) begin
         err_d = acc_oor;
      end else if ((state_q == RESP) && rsp_ready) begin
         err_d = 1'b0;
      end
   end
`else
   // Upper address bits only matter for the range check; here they alias.
   logic unused_addr_hi;
   assign unused_addr_hi = ^(req_addr >> DEPTH_LOG2);
   assign acc_oor        = 1'b0;
   assign rsp_rdata      = ram_rdata;
`endif

   // Out-of-range writes are dropped; the access still runs as a read so the
   // read register behaves the same and the masked output stays 0.
   assign ram_we = acc_we && !acc_oor;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ram_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               we_d    = req_we;
               addr_d  = req_addr[DEPTH_LOG2-1:0];
               wdata_d = req_wdata;
               cnt_d   = wait_cycles;
               if (wait_cycles == '0) begin
                  state_d = RESP;
                  ram_en  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            // Count reaches 0 exactly on the edge that enters RESP; it never wraps.
            cnt_d = cnt_q - WAIT_W'(1);
            if (cnt_q == WAIT_W'(1)) begin
               state_d = RESP;
               ram_en  = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef LC3_MEM_RESP_OOR_EN
         oor_q   <= 1'b0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef LC3_MEM_RESP_OOR_EN
         oor_q   <= oor_d;
         err_q   <= err_d;
`endif
      end
   end

   lc3_mem_resp_ram #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clock (clock),
      .reset (reset),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (acc_addr),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_lc3_mem_resp.sv
// tb_lc3_mem_resp
// Self-checking bench for lc3_mem_resp with default parameters. A model of
// the responder (word memory plus the single outstanding transaction and its
// due cycle) is compared against the DUT on every falling clock edge; the
// directed sequence adds hand-computed latency and data expectations.
// Define LC3_MEM_RESP_OOR_EN for both bench and RTL to exercise rsp_err.
module tb_lc3_mem_resp;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  wait_cycles = '0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_rdata;
`ifdef LC3_MEM_RESP_OOR_EN
   logic        rsp_err_w;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   lc3_mem_resp dut (
      .clock       (clock),
      .reset       (reset),
      .wait_cycles (wait_cycles),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata)
`ifdef LC3_MEM_RESP_OOR_EN
      ,
      .rsp_err     (rsp_err_w)
`endif
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic bit addr_oor(input logic [15:0] a);
`ifdef LC3_MEM_RESP_OOR_EN
      return a[15:8] != 8'h00;
`else
      return a[15:8] != a[15:8];
`endif
   endfunction

   // ---------------- model ----------------
   logic [15:0] mdl_mem   [256];
   bit          mdl_known [256];
   bit          pend   = 1'b0;
   bit          p_done = 1'b0;
   bit          p_we, p_oor;
   int          p_cyc, p_w;
   logic [7:0]  p_idx;
   logic [15:0] p_data;
   logic [15:0] exp_data;
   bit          exp_known;

   // The response is due wait+1 cycles after the handshake cycle; the access
   // takes effect at that moment, even if reset follows right after.
   function automatic bit is_due();
      return pend && (cyc >= p_cyc + p_w + 1);
   endfunction

   task automatic commit_if_due();
      if (is_due() && !p_done) begin
         p_done = 1'b1;
         if (p_oor) begin
            exp_data  = 16'h0000;
            exp_known = 1'b1;
         end else if (p_we) begin
            mdl_mem[p_idx]   = p_data;
            mdl_known[p_idx] = 1'b1;
            exp_data         = p_data;
            exp_known        = 1'b1;
         end else begin
            exp_data  = mdl_mem[p_idx];
            exp_known = mdl_known[p_idx];
         end
      end
   endtask

   always @(negedge clock) begin
      bit due;
      commit_if_due();
      due = is_due();
      if (reset) begin
         check("rst_req_ready", req_ready, 0);
         check("rst_rsp_valid", rsp_valid, 0);
`ifdef LC3_MEM_RESP_OOR_EN
         check("rst_rsp_err", rsp_err_w, 0);
`endif
         pend = 1'b0;
      end else begin
         check("req_ready", req_ready, !pend);
         check("rsp_valid", rsp_valid, due);
         if (due && exp_known) check("rsp_rdata", rsp_rdata, exp_data);
`ifdef LC3_MEM_RESP_OOR_EN
         check("rsp_err", rsp_err_w, due && p_oor);
`endif
         if (due && rsp_ready) begin
            pend = 1'b0;
         end else if (!pend && req_valid) begin
            pend   = 1'b1;
            p_done = 1'b0;
            p_cyc  = cyc;
            p_w    = int'(wait_cycles);
            p_we   = req_we;
            p_idx  = req_addr[7:0];
            p_data = req_wdata;
            p_oor  = addr_oor(req_addr);
         end
      end
   end

   // ---------------- drivers ----------------
   // One transaction. lat = cycles from handshake cycle to first rsp_valid.
   task automatic txn(input bit we, input logic [15:0] addr, input logic [15:0] data,
                      input int w, input int hold, input bit early,
                      output logic [15:0] rdata, output int lat, output bit err);
      int h;
      bit got;
      rdata = 'x; lat = -1; err = 1'b0; h = 0;
      @(posedge clock); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
      wait_cycles = 4'(w);
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clock);
         if (req_ready) begin got = 1'b1; h = cyc; end
      end
      check("accept_in_time", got, 1);
      @(posedge clock); #1;
      req_valid = 1'b0;
      // Changing wait_cycles after acceptance must not affect this transaction.
      wait_cycles = 4'($urandom_range(0, 15));
      if (!got) return;
      if (early) rsp_ready = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clock);
         if (rsp_valid) begin got = 1'b1; lat = cyc - h; end
      end
      check("response_in_time", got, 1);
      rdata = rsp_rdata;
`ifdef LC3_MEM_RESP_OOR_EN
      err = rsp_err_w;
`endif
      if (early) begin
         @(posedge clock); #1 rsp_ready = 1'b0;
      end else begin
         repeat (hold) @(negedge clock);
         @(posedge clock); #1 rsp_ready = 1'b1;
         @(posedge clock); #1 rsp_ready = 1'b0;
      end
   endtask

   // Accept a request, let n more edges pass, then pulse reset mid-transaction.
   task automatic txn_reset(input bit we, input logic [15:0] addr, input logic [15:0] data,
                            input int w, input int n, input bit pre_valid);
      bit got;
      @(posedge clock); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
      wait_cycles = 4'(w);
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clock);
         if (req_ready) got = 1'b1;
      end
      check("abort_accept_in_time", got, 1);
      @(posedge clock); #1 req_valid = 1'b0;
      repeat (n) @(posedge clock);
      #2;
      check("abort_pre_rsp_valid", rsp_valid, pre_valid);
      reset = 1'b1;
      #1;
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_req_ready", req_ready, 0);
      @(posedge clock); #3 reset = 1'b0;
      #1 check("abort_release_req_ready", req_ready, 1);
   endtask

   // ---------------- sequence ----------------
   initial begin
      logic [15:0] rd;
      int          lat;
      bit          er;

      repeat (3) @(posedge clock);
      #1;
      check("reset_rsp_rdata", rsp_rdata, 16'h0000);
      check("reset_req_ready", req_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      #1 reset = 1'b0;
      #1 check("post_reset_req_ready", req_ready, 1);

      // Zero-wait write then read-after-write.
      txn(1'b1, 16'h0010, 16'h1234, 0, 0, 1'b0, rd, lat, er);
      check("w0_write_lat", lat, 1);
      check("w0_write_data", rd, 16'h1234);
      txn(1'b0, 16'h0010, 16'h0000, 0, 0, 1'b0, rd, lat, er);
      check("w0_read_data", rd, 16'h1234);

      // Five wait states: response six cycles after the handshake.
      txn(1'b0, 16'h0010, 16'h0000, 5, 0, 1'b0, rd, lat, er);
      check("w5_read_lat", lat, 6);
      check("w5_read_data", rd, 16'h1234);

      // Response backpressure held for four cycles.
      txn(1'b1, 16'h0020, 16'h0001, 2, 4, 1'b0, rd, lat, er);
      check("hold_lat", lat, 3);
      check("hold_data", rd, 16'h0001);

      // Reset during WAIT drops the write.
      txn_reset(1'b1, 16'h0020, 16'hBEEF, 6, 2, 1'b0);
      txn(1'b0, 16'h0020, 16'h0000, 1, 0, 1'b0, rd, lat, er);
      check("abort_wait_read", rd, 16'h0001);

      // Reset during RESP keeps the already committed write.
      txn_reset(1'b1, 16'h0030, 16'h7777, 0, 0, 1'b1);
      txn(1'b0, 16'h0030, 16'h0000, 3, 0, 1'b0, rd, lat, er);
      check("abort_resp_read", rd, 16'h7777);

      // Maximum wait, with rsp_ready already high before RESP.
      txn(1'b0, 16'h0010, 16'h0000, 15, 0, 1'b1, rd, lat, er);
      check("w15_read_lat", lat, 16);
      check("w15_read_data", rd, 16'h1234);

`ifdef LC3_MEM_RESP_OOR_EN
      txn(1'b1, 16'h0005, 16'h5555, 0, 0, 1'b0, rd, lat, er);
      txn(1'b1, 16'h0105, 16'hAAAA, 1, 0, 1'b0, rd, lat, er);
      check("oor_write_err", er, 1);
      check("oor_write_data", rd, 16'h0000);
      txn(1'b0, 16'h0005, 16'h0000, 0, 0, 1'b0, rd, lat, er);
      check("oor_after_err", er, 0);
      check("oor_after_data", rd, 16'h5555);
      txn(1'b0, 16'h0105, 16'h0000, 2, 0, 1'b0, rd, lat, er);
      check("oor_read_err", er, 1);
      check("oor_read_data", rd, 16'h0000);
`else
      // Upper address bits alias onto the same word.
      txn(1'b1, 16'h0142, 16'hCAFE, 0, 0, 1'b0, rd, lat, er);
      txn(1'b0, 16'h0042, 16'h0000, 2, 0, 1'b0, rd, lat, er);
      check("alias_read", rd, 16'hCAFE);
`endif

      // Fill every word with its inverted address, then read all back.
      for (int i = 0; i < 256; i++) begin
         logic [15:0] a;
         a = 16'(i);
         txn(1'b1, a, a ^ 16'hFFFF, int'($urandom_range(0, 15)), 0, 1'b0, rd, lat, er);
      end
      for (int i = 0; i < 256; i++) begin
         logic [15:0] a;
         a = 16'(i);
         txn(1'b0, a, 16'h0000, int'($urandom_range(0, 15)), 0, 1'b0, rd, lat, er);
         check("sweep_read", rd, a ^ 16'hFFFF);
      end

      repeat (2) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
